// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: RAM commands, arbiter
// states and a counter-width helper.
package mem_port_arbiter_pkg;

  // RAM command encodings driven on o_ram_action
  localparam logic [1:0] RAM_NONE  = 2'd0;
  localparam logic [1:0] RAM_READ  = 2'd1;
  localparam logic [1:0] RAM_WRITE = 2'd2;

  // Arbiter FSM state encodings
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  // Bits needed to hold 0..limit (never less than one bit)
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// Used both as the RAM wait timer and as the fetch starvation counter.
module mem_port_arbiter_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int WIDTH = cnt_width(LIMIT);

  logic [WIDTH-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == WIDTH'(LIMIT));
  assign o_tc = w_tc;

  // Count up on request, hold at LIMIT, clear has priority over increment
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single RAM port: instruction fetch (F) and
// data access (D). One RAM transaction at a time, bounded by a wait timeout,
// with a starvation limit that guarantees fetch forward progress.
//
// Handshake: a requester raises i_x_req with its address/data/action and
// holds it until its one-cycle o_x_ack. Inputs are sampled only in the IDLE
// cycle that grants the request. The ack cycle is a drop cycle: no grant is
// made while any ack is high, so a requester may withdraw or replace its
// request then. o_err only ever accompanies an ack (timed-out transaction).
// The RAM side is command/ready: o_ram_* holds steady until i_ram_ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_ack,
  output logic [DATA_W-1:0] o_f_rdata,
  input  logic              i_d_req,
  input  logic [1:0]        i_d_action,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_err,
  output logic [1:0]        o_ram_action,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  input  logic              i_ram_ready,
  output logic              o_busy,
  output arb_state_t        o_dbg_state
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;

  logic [1:0]        r_ram_action;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_f_ack;
  logic              r_d_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_idle;
  logic w_busy;
  logic w_drop;
  logic w_d_mem_action;
  logic w_d_win;
  logic w_f_win;
  logic w_d_none;
  logic w_d_mem;
  logic w_done;
  logic w_tout;
  logic w_starve_tc;
  logic w_wait_tc;
  logic w_wait_clr;
  logic w_wait_inc;
  logic w_starve_inc;

  assign w_idle = (r_state == ARB_IDLE);
  assign w_busy = !w_idle;
  assign w_drop = r_f_ack || r_d_ack;

  assign w_d_mem_action = (i_d_action == RAM_READ) || (i_d_action == RAM_WRITE);

  // D wins unless fetch is waiting and D has used up its starvation budget
  assign w_d_win  = w_idle && !w_drop && i_d_req && !(i_f_req && w_starve_tc);
  assign w_f_win  = w_idle && !w_drop && !w_d_win && i_f_req;
  assign w_d_none = w_d_win && !w_d_mem_action;
  assign w_d_mem  = w_d_win && w_d_mem_action;

  // Ready beats timeout when both land in the same cycle
  assign w_done = w_busy && i_ram_ready;
  assign w_tout = w_busy && !i_ram_ready && w_wait_tc;

  assign w_wait_clr   = w_idle || w_done || w_tout;
  assign w_wait_inc   = w_busy && !i_ram_ready;
  assign w_starve_inc = w_d_win && i_f_req;

  mem_port_arbiter_wait_timer #(
    .LIMIT (TIMEOUT - 1)
  ) u_wait_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_wait_clr),
    .i_inc (w_wait_inc),
    .o_tc  (w_wait_tc)
  );

  mem_port_arbiter_wait_timer #(
    .LIMIT (STARVE_LIM)
  ) u_starve_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_f_win),
    .i_inc (w_starve_inc),
    .o_tc  (w_starve_tc)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: grants leave IDLE, completion or timeout returns to it
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_d_mem) begin
          w_next_state = ARB_DATA;
        end else if (w_f_win) begin
          w_next_state = ARB_FETCH;
        end
      end
      ARB_FETCH, ARB_DATA: begin
        if (w_done || w_tout) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy      = w_busy;
    o_dbg_state = r_state;
  end

  // RAM command, acks, error and read-data registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ram_action <= RAM_NONE;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_f_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_err        <= 1'b0;
      r_f_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_f_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_err   <= 1'b0;
      if (w_d_none) begin
        r_d_ack <= 1'b1;
      end else if (w_d_mem) begin
        r_ram_action <= i_d_action;
        r_ram_addr   <= i_d_addr;
        r_ram_wdata  <= i_d_wdata;
      end else if (w_f_win) begin
        r_ram_action <= RAM_READ;
        r_ram_addr   <= i_f_addr;
      end else if (w_done) begin
        r_ram_action <= RAM_NONE;
        if (r_state == ARB_FETCH) begin
          r_f_ack   <= 1'b1;
          r_f_rdata <= i_ram_rdata;
        end else begin
          r_d_ack <= 1'b1;
          if (r_ram_action == RAM_READ) begin
            r_d_rdata <= i_ram_rdata;
          end
        end
      end else if (w_tout) begin
        r_ram_action <= RAM_NONE;
        r_err        <= 1'b1;
        if (r_state == ARB_FETCH) begin
          r_f_ack   <= 1'b1;
          r_f_rdata <= '0;
        end else begin
          r_d_ack   <= 1'b1;
          r_d_rdata <= '0;
        end
      end
    end
  end

  assign o_ram_action = r_ram_action;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_wdata  = r_ram_wdata;
  assign o_f_ack      = r_f_ack;
  assign o_d_ack      = r_d_ack;
  assign o_err        = r_err;
  assign o_f_rdata    = r_f_rdata;
  assign o_d_rdata    = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester drivers, a RAM responder, a
// transaction-level reference model and a scoreboard monitor.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_LIM = 4;
  localparam int TIMEOUT    = 8;

  logic              i_clk;
  logic              i_rst;
  logic              i_f_req;
  logic [ADDR_W-1:0] i_f_addr;
  logic              o_f_ack;
  logic [DATA_W-1:0] o_f_rdata;
  logic              i_d_req;
  logic [1:0]        i_d_action;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_ack;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_err;
  logic [1:0]        o_ram_action;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [DATA_W-1:0] i_ram_rdata;
  logic              i_ram_ready;
  logic              o_busy;
  arb_state_t        o_dbg_state;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_LIM (STARVE_LIM),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_f_req      (i_f_req),
    .i_f_addr     (i_f_addr),
    .o_f_ack      (o_f_ack),
    .o_f_rdata    (o_f_rdata),
    .i_d_req      (i_d_req),
    .i_d_action   (i_d_action),
    .i_d_addr     (i_d_addr),
    .i_d_wdata    (i_d_wdata),
    .o_d_ack      (o_d_ack),
    .o_d_rdata    (o_d_rdata),
    .o_err        (o_err),
    .o_ram_action (o_ram_action),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wdata  (o_ram_wdata),
    .i_ram_rdata  (i_ram_rdata),
    .i_ram_ready  (i_ram_ready),
    .o_busy       (o_busy),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [DATA_W:0]   f_exp_q[$];   // {err, rdata} per fetch
  logic [DATA_W:0]   d_exp_q[$];   // {err, rdata} per data access
  logic [ADDR_W-1:0] f_cmd_q[$];   // fetch addresses the RAM must see
  logic [65:0]       d_cmd_q[$];   // {action, addr, wdata} the RAM must see
  bit                ack_log[$];   // 1 = D ack, 0 = F ack, in order
  logic [DATA_W-1:0] model_d_rdata;
  int                force_lat = 0;
  int                last_d_ack_cyc = 0;
  int                last_f_cmd_cyc = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: RAM contents are a fixed function of address; any
  // address with bit 12 set is a dead location that never answers.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50000 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic bit is_dead(input logic [31:0] a);
    return a[12];
  endfunction

  function automatic int d_before_first_f();
    int n;
    n = 0;
    foreach (ack_log[i]) begin
      if (!ack_log[i]) return n;
      n++;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after a rising edge with
  // the request dropped, so consecutive calls hold the request back-to-back.
  task automatic f_txn(input logic [31:0] addr, output int lat);
    i_f_req  = 1'b1;
    i_f_addr = addr;
    f_exp_q.push_back(is_dead(addr) ? {1'b1, 32'h0} : {1'b0, ram_word(addr)});
    f_cmd_q.push_back(addr);
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (!o_f_ack && lat < 200);
    check("f_ack_seen", o_f_ack, 1'b1);
    @(posedge i_clk);
    #1;
    i_f_req = 1'b0;
  endtask

  task automatic d_txn(input logic [1:0] act, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output int busy_cycles);
    logic [DATA_W:0] e;
    i_d_req    = 1'b1;
    i_d_action = act;
    i_d_addr   = addr;
    i_d_wdata  = wdata;
    if (act == RAM_READ || act == RAM_WRITE) begin
      d_cmd_q.push_back({act, addr, wdata});
      if (is_dead(addr)) begin
        model_d_rdata = '0;
        e = {1'b1, 32'h0};
      end else begin
        if (act == RAM_READ) model_d_rdata = ram_word(addr);
        e = {1'b0, model_d_rdata};
      end
    end else begin
      e = {1'b0, model_d_rdata};
    end
    d_exp_q.push_back(e);
    lat = 0;
    busy_cycles = 0;
    do begin
      @(negedge i_clk);
      lat++;
      if (o_busy) busy_cycles++;
    end while (!o_d_ack && lat < 200);
    check("d_ack_seen", o_d_ack, 1'b1);
    @(posedge i_clk);
    #1;
    i_d_req = 1'b0;
  endtask

  // ---------------- RAM responder ----------------
  initial begin
    logic [31:0] a;
    logic [1:0]  act;
    logic [65:0] ce;
    int          lat;
    int          k;
    i_ram_ready = 1'b0;
    i_ram_rdata = '0;
    forever begin
      @(posedge i_clk);
      #1;
      i_ram_ready = 1'b0;
      if (!i_rst && o_ram_action != RAM_NONE) begin
        a   = o_ram_addr;
        act = o_ram_action;
        if (a[28]) begin
          check("d_cmd_expected", (d_cmd_q.size() != 0), 1'b1);
          if (d_cmd_q.size() != 0) begin
            ce = d_cmd_q.pop_front();
            check("d_cmd_action", act, ce[65:64]);
            check("d_cmd_addr", a, ce[63:32]);
            if (act == RAM_WRITE) check("d_cmd_wdata", o_ram_wdata, ce[31:0]);
          end
        end else begin
          last_f_cmd_cyc = cyc;
          check("f_cmd_action", act, RAM_READ);
          check("f_cmd_expected", (f_cmd_q.size() != 0), 1'b1);
          if (f_cmd_q.size() != 0) check("f_cmd_addr", a, f_cmd_q.pop_front());
        end
        if (is_dead(a)) lat = 0;
        else if (force_lat > 0) lat = force_lat;
        else lat = $urandom_range(1, TIMEOUT);
        k = 1;
        forever begin
          if (k == lat) begin
            i_ram_ready = 1'b1;
            i_ram_rdata = (act == RAM_READ) ? ram_word(a) : $urandom;
          end
          @(posedge i_clk);
          #1;
          i_ram_ready = 1'b0;
          if (i_rst || o_ram_action == RAM_NONE) break;
          k++;
          if (k > 4 * TIMEOUT) begin
            check("ram_cmd_released", 1'b0, 1'b1);
            break;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    logic [DATA_W:0] e;
    if (!i_rst) begin
      check("err_only_with_ack", (o_err && !o_f_ack && !o_d_ack), 1'b0);
      if (o_f_ack) begin
        ack_log.push_back(1'b0);
        check("f_ack_expected", (f_exp_q.size() != 0), 1'b1);
        if (f_exp_q.size() != 0) begin
          e = f_exp_q.pop_front();
          check("f_rdata", o_f_rdata, e[31:0]);
          check("f_err", o_err, e[32]);
        end
      end
      if (o_d_ack) begin
        ack_log.push_back(1'b1);
        last_d_ack_cyc = cyc;
        check("d_ack_expected", (d_exp_q.size() != 0), 1'b1);
        if (d_exp_q.size() != 0) begin
          e = d_exp_q.pop_front();
          check("d_rdata", o_d_rdata, e[31:0]);
          check("d_err", o_err, e[32]);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int bsy;
    int c0;
    i_rst      = 1'b1;
    i_f_req    = 1'b0;
    i_f_addr   = '0;
    i_d_req    = 1'b0;
    i_d_action = RAM_NONE;
    i_d_addr   = '0;
    i_d_wdata  = '0;
    model_d_rdata = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ram_action", o_ram_action, RAM_NONE);
    check("rst_ram_addr", o_ram_addr, 0);
    check("rst_ram_wdata", o_ram_wdata, 0);
    check("rst_f_ack", o_f_ack, 0);
    check("rst_d_ack", o_d_ack, 0);
    check("rst_err", o_err, 0);
    check("rst_f_rdata", o_f_rdata, 0);
    check("rst_d_rdata", o_d_rdata, 0);
    check("rst_busy", o_busy, 0);
    check("rst_state", o_dbg_state, ARB_IDLE);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Fetch alone: command one cycle after grant, ack one cycle after ready
    force_lat = 3;
    c0 = cyc;
    f_txn(32'h0000_0100, lat);
    check("a_cmd_cycle", last_f_cmd_cyc - c0, 1);
    check("a_ack_latency", lat, 5);
    @(negedge i_clk);
    check("a_ack_one_cycle", o_f_ack, 1'b0);
    @(posedge i_clk);
    #1;

    // Simultaneous F and D read: D first, F command two cycles after D ack
    force_lat = 2;
    ack_log.delete();
    fork
      f_txn(32'h0000_0104, lat);
      d_txn(RAM_READ, 32'h1000_0200, 32'h0, lat, bsy);
    join
    check("b_ack_count", ack_log.size(), 2);
    check("b_d_first", d_before_first_f(), 1);
    check("b_f_grant_gap", last_f_cmd_cyc - last_d_ack_cyc, 2);

    // D with no RAM action: ack next cycle, never busy, rdata unchanged
    d_txn(RAM_NONE, 32'h1000_0400, 32'h0, lat, bsy);
    check("e_none_latency", lat, 2);
    check("e_none_busy", bsy, 0);

    // Back-to-back D writes with F pending: exactly STARVE_LIM D first
    force_lat = 0;
    for (int rep = 0; rep < 2; rep++) begin
      ack_log.delete();
      fork
        f_txn(32'h0000_0108 + 32'(rep * 4), lat);
        begin
          for (int i = 0; i < 6; i++) begin
            d_txn(RAM_WRITE, 32'h1000_0300 + 32'(i * 4), $urandom, lat, bsy);
          end
        end
      join
      check("c_d_before_f", d_before_first_f(), STARVE_LIM);
    end

    // Write that never completes: timeout after TIMEOUT busy cycles
    d_txn(RAM_WRITE, 32'h1000_1300, 32'h1234_5678, lat, bsy);
    check("d_tout_busy", bsy, TIMEOUT);
    check("d_tout_ram_none", o_ram_action, RAM_NONE);

    // Ready on the last allowed cycle beats the timeout
    force_lat = TIMEOUT;
    d_txn(RAM_READ, 32'h1000_0500, 32'h0, lat, bsy);
    check("g_edge_busy", bsy, TIMEOUT);
    f_txn(32'h0000_0200, lat);
    force_lat = 0;

    // Randomised concurrent traffic from both requesters
    fork
      begin
        logic [31:0] fa;
        int fl;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge i_clk);
            #1;
          end
          fa = 32'h0000_0000 | (32'($urandom_range(0, 255)) << 2);
          if ($urandom_range(0, 7) == 0) fa[12] = 1'b1;
          f_txn(fa, fl);
        end
      end
      begin
        logic [31:0] da;
        logic [1:0]  dact;
        int dl;
        int db;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge i_clk);
            #1;
          end
          da = 32'h1000_0000 | (32'($urandom_range(0, 255)) << 2);
          if ($urandom_range(0, 7) == 0) da[12] = 1'b1;
          dact = 2'($urandom_range(0, 2));
          d_txn(dact, da, $urandom, dl, db);
        end
      end
    join

    // Reset one cycle into DATA abandons the access without an ack
    i_d_req    = 1'b1;
    i_d_action = RAM_READ;
    i_d_addr   = 32'h1000_1500;
    d_cmd_q.push_back({RAM_READ, 32'h1000_1500, 32'h0});
    @(negedge i_clk);
    @(negedge i_clk);
    check("r_in_data", o_dbg_state, ARB_DATA);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("r_ram_action", o_ram_action, RAM_NONE);
    check("r_ram_addr", o_ram_addr, 0);
    check("r_d_ack", o_d_ack, 0);
    check("r_err", o_err, 0);
    check("r_d_rdata", o_d_rdata, 0);
    check("r_busy", o_busy, 0);
    @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    i_d_req = 1'b0;
    model_d_rdata = '0;
    @(negedge i_clk);
    check("r_no_late_ack", o_d_ack, 0);
    @(posedge i_clk);
    #1;
    f_txn(32'h0000_0300, lat);
    d_txn(RAM_NONE, 32'h1000_0000, 32'h0, lat, bsy);

    repeat (4) @(posedge i_clk);
    check("end_f_exp_empty", f_exp_q.size(), 0);
    check("end_d_exp_empty", d_exp_q.size(), 0);
    check("end_f_cmd_empty", f_cmd_q.size(), 0);
    check("end_d_cmd_empty", d_cmd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single RAM port between two requesters: instruction fetch (F) and the data-access path (D). D carries LD/LDA/ST traffic.
- Sits between the fetch/control logic and the RAM.
- Serialises requests and sequences each RAM transaction through a ready handshake.
- Guarantees fetch forward progress with a starvation limit and bounds every transaction with a timeout.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIM, 4, max consecutive D grants while F is pending
- TIMEOUT, 255, max wait cycles for i_ram_ready before abort (must be ≥1)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_f_req  in  1  fetch request, held until o_f_ack
- i_f_addr  in  ADDR_W  fetch address
- o_f_ack  out  1  one-cycle fetch completion pulse
- o_f_rdata  out  DATA_W  fetched word, valid with o_f_ack
- i_d_req  in  1  data request, held until o_d_ack
- i_d_action  in  2  `RAM_NONE/`RAM_READ/`RAM_WRITE
- i_d_addr  in  ADDR_W  data address
- i_d_wdata  in  DATA_W  store data
- o_d_ack  out  1  one-cycle data completion pulse
- o_d_rdata  out  DATA_W  load data, valid with o_d_ack on reads
- o_err  out  1  pulses with the ack of a timed-out transaction
- o_ram_action  out  2  RAM command, registered
- o_ram_addr  out  ADDR_W  RAM address, registered
- o_ram_wdata  out  DATA_W  RAM write data, registered
- i_ram_rdata  in  DATA_W  RAM read data, sampled on i_ram_ready
- i_ram_ready  in  1  RAM completes the current command this cycle
- o_busy  out  1  high in state FETCH or DATA

Behaviour:
- Single clock i_clk; reset i_rst is synchronous and active-high.
- Reset state:
  - state=IDLE
  - o_ram_action=`RAM_NONE; o_ram_addr=0; o_ram_wdata=0
  - o_f_ack=0, o_d_ack=0, o_err=0
  - o_f_rdata=0, o_d_rdata=0
  - wait_cnt=0, starve_cnt=0
- Reset mid-transaction abandons the transaction: no ack is issued, and RAM sees `RAM_NONE the next cycle.
- FSM states: IDLE, FETCH, DATA.
- IDLE arbitration:
  - No grant in any cycle where o_f_ack or o_d_ack is high. This is the requester drop cycle.
  - D wins if i_d_req && !(i_f_req && starve_cnt==STARVE_LIM).
  - Otherwise F wins if i_f_req.
- Grant to D with i_d_action==`RAM_NONE:
  - No RAM access, state stays IDLE.
  - o_d_ack pulses next cycle; o_d_rdata unchanged.
- Grant to D with READ/WRITE:
  - Latch i_d_addr and i_d_wdata into the RAM registers; o_ram_action=i_d_action.
  - Go to DATA.
- Grant to F: latch i_f_addr; o_ram_action=`RAM_READ; go to FETCH.
- Starvation counter:
  - Increments (saturating at STARVE_LIM) on each D grant made while i_f_req=1.
  - Clears on each F grant.
- Cycle in FETCH/DATA with i_ram_ready=1:
  - Next cycle: owning ack=1 and o_ram_action=`RAM_NONE.
  - rdata register ← i_ram_rdata for FETCH, and for DATA reads. DATA writes leave o_d_rdata unchanged.
  - State returns to IDLE; wait_cnt cleared.
- Cycle in FETCH/DATA with i_ram_ready=0:
  - wait_cnt increments.
  - When wait_cnt reaches TIMEOUT-1 with no ready: the owning ack and o_err=1 pulse next cycle, rdata=0, o_ram_action=`RAM_NONE, return to IDLE.
  - If ready and the timeout coincide, ready wins and o_err=0.
- Latency: grant at cycle G; RAM command visible G+1; ready at R≥G+1; ack at R+1; next grant earliest R+2.
- Requester inputs are ignored outside the IDLE grant cycle. Addresses and data are captured only at grant.
- o_err is never high without an ack.
- Counters wrap nowhere; all are saturating or cleared as stated.

Decomposition:
- Shared defines header:
  - `RAM_NONE/`RAM_READ/`RAM_WRITE, reused from the existing defines
  - new `ARB_IDLE/`ARB_FETCH/`ARB_DATA state encodings (2 bits)
- One natural sub-module: arb_wait_timer. It is a loadable/clearable counter with a terminal-count flag and serves both wait_cnt and starve_cnt, parameterised by limit.

Test Plan:
- F only: i_f_addr=0x100, ram_ready 2 cycles after command, rdata=0xDEADBEEF -> ram_action READ at G+1; o_f_ack one cycle with o_f_rdata=0xDEADBEEF; o_err=0.
- Simultaneous F and D(READ 0x200), STARVE_LIM=4, starve_cnt=0 -> D granted first, o_d_ack, then F granted at R+2.
- D held continuously as back-to-back WRITEs with F pending, STARVE_LIM=4 -> exactly 4 D grants, then F granted; starve_cnt returns to 0.
- D(WRITE 0x300, wdata=0x12345678), TIMEOUT=8, ram_ready never -> after 8 wait cycles, o_d_ack=1 and o_err=1 in the same cycle; o_d_rdata=0; ram_action NONE.
- D with action `RAM_NONE -> o_d_ack next cycle, ram_action stays NONE throughout, state stays IDLE.
- i_rst asserted one cycle into DATA -> next cycle all outputs at reset values, no ack; a subsequent F request is serviced normally.
